simon_key_expand: RTL

//  Iterative Simon32/64 key-schedule unit sitting directly upstream of the 32-stage encryption pipeline.

---
 rtl/simon_key_expand_pkg.sv | 32 +++
 rtl/simon_key_expand_if.sv | 28 ++
 rtl/simon_key_expand_round_fn.sv | 18 +
 rtl/simon_key_expand.sv | 84 ++++++++
 4 files changed

// File: rtl/simon_key_expand_pkg.sv
// Shared types and constants for the Simon32/64 key-schedule unit.
// Holds the z0 sequence, the round constant and the rotate helper used by the round function.
package simon_key_expand_pkg;

  localparam int SIMON_WORD_W    = 16;
  localparam int SIMON_ROUNDS    = 32;
  localparam int SIMON_KEY_WORDS = 4;

  localparam logic [61:0] SIMON_Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  // ~x ^ 16'h0003 folded into a single XOR constant
  localparam logic [15:0] SIMON_C = 16'hFFFC;

  typedef logic [SIMON_ROUNDS-1:0][SIMON_WORD_W-1:0] simon_rk_arr_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } simon_kx_state_t;

  // j counts from the most significant (leftmost) bit of the sequence
  function automatic logic z0_bit(input logic [4:0] j);
    return SIMON_Z0[6'd61 - {1'b0, j}];
  endfunction

  function automatic logic [15:0] ror16(input logic [15:0] x, input int unsigned s);
    return (x >> s) | (x << (16 - s));
  endfunction

endpackage

// File: rtl/simon_key_expand_if.sv
// Key-load request and round-key file bundle between the key schedule and its consumers.
// The slave side is the key-schedule unit; the master side loads keys and reads round keys.
interface simon_key_expand_if;
  import simon_key_expand_pkg::*;

  logic [63:0]   key_in;
  logic          key_load;
  logic          key_busy;
  logic          key_valid;
  simon_rk_arr_t round_key;

  modport master (
    output key_in,
    output key_load,
    input  key_busy,
    input  key_valid,
    input  round_key
  );

  modport slave (
    input  key_in,
    input  key_load,
    output key_busy,
    output key_valid,
    output round_key
  );

endinterface

// File: rtl/simon_key_expand_round_fn.sv
// Combinational Simon32/64 key-schedule step for m=4: produces k[i] from k[i-4], k[i-3], k[i-1]
// and the z0 sequence bit for index i-4.
module simon_key_expand_round_fn
  import simon_key_expand_pkg::*;
(
  input  logic [15:0] k_m4_i,
  input  logic [15:0] k_m3_i,
  input  logic [15:0] k_m1_i,
  input  logic        z_i,
  output logic [15:0] rk_o
);

  logic [15:0] t;

  assign t    = ror16(k_m1_i, 3) ^ k_m3_i;
  assign rk_o = SIMON_C ^ k_m4_i ^ t ^ ror16(t, 1) ^ {15'b0, z_i};

endmodule

// File: rtl/simon_key_expand.sv
// Iterative Simon32/64 key expansion: loads a 64-bit master key, then writes one round key
// per cycle into a 32-entry register file that feeds the encryption pipeline directly.
module simon_key_expand
  import simon_key_expand_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int ROUNDS    = 32,
  parameter int KEY_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  simon_key_expand_if.slave        kx
);

  localparam logic [4:0] CNT_START = 5'(KEY_WORDS);
  localparam logic [4:0] CNT_LAST  = 5'(ROUNDS - 1);

  simon_kx_state_t   state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  simon_rk_arr_t     rk_q, rk_d;

  logic [WORD_W-1:0] src_m4, src_m3, src_m1, f_word;
  logic [4:0]        z_idx;
  logic              z_bit;

  // Read-mux of the three source words for the entry being written this cycle
  assign src_m4 = rk_q[cnt_q - 5'd4];
  assign src_m3 = rk_q[cnt_q - 5'd3];
  assign src_m1 = rk_q[cnt_q - 5'd1];
  assign z_idx  = cnt_q - 5'd4;
  assign z_bit  = z0_bit(z_idx);

  simon_key_expand_round_fn u_round_fn (
    .k_m4_i (src_m4),
    .k_m3_i (src_m3),
    .k_m1_i (src_m1),
    .z_i    (z_bit),
    .rk_o   (f_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rk_d    = rk_q;
    case (state_q)
      IDLE, DONE: begin
        if (kx.key_load) begin
          for (int w = 0; w < KEY_WORDS; w++) begin
            rk_d[w] = kx.key_in[w*WORD_W +: WORD_W];
          end
          cnt_d   = CNT_START;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        // Loads are ignored here; the counter parks at the last index instead of wrapping
        rk_d[cnt_q] = f_word;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
    end
  end

  assign kx.key_busy  = (state_q == EXPAND);
  assign kx.key_valid = (state_q == DONE);
  assign kx.round_key = rk_q;

endmodule
